lock_ctrl: RTL and testbench

//  Sequencing controller for the combination-lock path. Accepts keypad digits over a valid/ready

---
 rtl/lock_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_lock_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lock_ctrl.sv
// Combination-lock sequencer: keypad digit entry, code compare, failure lockout,
// timed unlock window and in-window reprogramming of the stored code.
module lock_ctrl #(
  parameter int unsigned                       DIGIT_W      = 4,
  parameter int unsigned                       CODE_LEN     = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0]       DEFAULT_CODE = 16'h1001,
  parameter int unsigned                       MAX_FAIL     = 3,
  parameter int unsigned                       LOCKOUT_CYC  = 1000,
  parameter int unsigned                       UNLOCK_CYC   = 500,
  parameter int unsigned                       TIMEOUT_CYC  = 2000
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              key_valid,
  input  logic [DIGIT_W-1:0]                key_digit,
  output logic                              key_ready,
  input  logic                              prog_en,
  input  logic                              relock,
  output logic [2:0]                        state_o,
  output logic                              unlocked,
  output logic                              locked_out,
  output logic                              bad_code,
  output logic                              abort,
  output logic                              prog_done,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

  localparam int unsigned CW      = CODE_LEN * DIGIT_W;
  localparam int unsigned FW      = $clog2(MAX_FAIL + 1);
  localparam int unsigned CNT_W   = $clog2(CODE_LEN + 1);
  localparam int unsigned TMR_M0  = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
  localparam int unsigned TMR_MAX = (TIMEOUT_CYC > TMR_M0) ? TIMEOUT_CYC : TMR_M0;
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      entry_buf, shadow_buf, code_reg;
  logic [CW-1:0]      entry_ins, shadow_ins;
  logic [CNT_W-1:0]   digit_cnt, shadow_cnt;
  logic [TW-1:0]      tmr;
  logic [FW-1:0]      fail_nxt, fail_inc;
  logic               accept;
  logic               buf_wr, shadow_wr, shadow_clr, commit, tmr_clr;
  logic               bad_nxt, abort_nxt, prog_done_nxt;

  assign accept     = key_valid & key_ready;
  assign fail_inc   = fail_cnt + FW'(1);
  assign state_o    = state;
  assign unlocked   = (state == S_OPEN);
  assign locked_out = (state == S_LOCKOUT);

  // Candidate buffers with the incoming digit dropped into the next slot (slot 0 = MSB digit)
  always_comb begin
    entry_ins  = entry_buf;
    shadow_ins = shadow_buf;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (digit_cnt == CNT_W'(i))
        entry_ins[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = key_digit;
      if (shadow_cnt == CNT_W'(i))
        shadow_ins[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = key_digit;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    fail_nxt      = fail_cnt;
    bad_nxt       = 1'b0;
    abort_nxt     = 1'b0;
    prog_done_nxt = 1'b0;
    buf_wr        = 1'b0;
    shadow_wr     = 1'b0;
    shadow_clr    = 1'b0;
    commit        = 1'b0;
    tmr_clr       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          buf_wr    = 1'b1;
          state_nxt = (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
        end
      end
      S_ENTRY: begin
        // an accept in the timeout cycle takes priority over the timeout
        if (accept) begin
          buf_wr  = 1'b1;
          tmr_clr = 1'b1;
          if (digit_cnt == CNT_W'(CODE_LEN - 1)) state_nxt = S_CHECK;
        end else if (tmr == TW'(TIMEOUT_CYC - 1)) begin
          state_nxt = S_IDLE;
          abort_nxt = 1'b1;
        end
      end
      S_CHECK: begin
        if (entry_buf == code_reg) begin
          state_nxt = S_OPEN;
          fail_nxt  = '0;
        end else begin
          bad_nxt   = 1'b1;
          fail_nxt  = fail_inc;
          state_nxt = (fail_inc == FW'(MAX_FAIL)) ? S_LOCKOUT : S_IDLE;
        end
      end
      S_OPEN: begin
        if (relock) begin
          state_nxt = S_IDLE;
        end else if (prog_en && accept) begin
          shadow_wr = 1'b1;
          tmr_clr   = 1'b1;
          if (shadow_cnt == CNT_W'(CODE_LEN - 1)) begin
            commit        = 1'b1;
            prog_done_nxt = 1'b1;
            shadow_clr    = 1'b1;
          end
        end else begin
          if (!prog_en) shadow_clr = 1'b1;
          if (tmr == TW'(UNLOCK_CYC - 1)) state_nxt = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (tmr == TW'(LOCKOUT_CYC - 1)) begin
          state_nxt = S_IDLE;
          fail_nxt  = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath, timers and registered status outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      entry_buf  <= '0;
      digit_cnt  <= '0;
      shadow_buf <= '0;
      shadow_cnt <= '0;
      code_reg   <= DEFAULT_CODE;
      tmr        <= '0;
      fail_cnt   <= '0;
      bad_code   <= 1'b0;
      abort      <= 1'b0;
      prog_done  <= 1'b0;
      key_ready  <= 1'b1;
    end else begin
      bad_code  <= bad_nxt;
      abort     <= abort_nxt;
      prog_done <= prog_done_nxt;
      fail_cnt  <= fail_nxt;
      key_ready <= (state_nxt == S_IDLE) || (state_nxt == S_ENTRY) ||
                   ((state_nxt == S_OPEN) && prog_en);

      if (state_nxt != state || tmr_clr) tmr <= '0;
      else if (tmr != TW'(TMR_MAX))      tmr <= tmr + TW'(1);

      if (state_nxt == S_IDLE) begin
        entry_buf <= '0;
        digit_cnt <= '0;
      end else if (buf_wr) begin
        entry_buf <= entry_ins;
        digit_cnt <= digit_cnt + CNT_W'(1);
      end

      if (state_nxt != S_OPEN || shadow_clr) begin
        shadow_buf <= '0;
        shadow_cnt <= '0;
      end else if (shadow_wr) begin
        shadow_buf <= shadow_ins;
        shadow_cnt <= shadow_cnt + CNT_W'(1);
      end

      if (commit) code_reg <= shadow_ins;
    end
  end

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl: entry, check latency, lockout, timeout, reprogramming, relock.
module tb_lock_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       key_ready;
  logic       prog_en;
  logic       relock;
  logic [2:0] state_o;
  logic       unlocked;
  logic       locked_out;
  logic       bad_code;
  logic       abort;
  logic       prog_done;
  logic [1:0] fail_cnt;

  int n_cmp = 0;
  int n_err = 0;

  lock_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .key_ready  (key_ready),
    .prog_en    (prog_en),
    .relock     (relock),
    .state_o    (state_o),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .bad_code   (bad_code),
    .abort      (abort),
    .prog_done  (prog_done),
    .fail_cnt   (fail_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic entry4(input logic [15:0] c);
    send(c[15:12]);
    send(c[11:8]);
    send(c[7:4]);
    send(c[3:0]);
  endtask

  task automatic do_relock();
    relock = 1'b1;
    tick();
    relock = 1'b0;
  endtask

  initial begin
    key_valid = 1'b0;
    key_digit = 4'd0;
    prog_en   = 1'b0;
    relock    = 1'b0;
    repeat (3) tick();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_ready", 32'(key_ready), 32'd1);
    chk("rst_unlocked", 32'(unlocked), 32'd0);
    chk("rst_locked_out", 32'(locked_out), 32'd0);
    chk("rst_fail", 32'(fail_cnt), 32'd0);
    chk("rst_pulses", 32'({bad_code, abort, prog_done}), 32'd0);
    RST = 1'b0;
    tick();

    // T1: default code, check latency and unlock window length
    entry4(16'h1001);
    chk("t1_check_state", 32'(state_o), 32'd2);
    chk("t1_check_ready", 32'(key_ready), 32'd0);
    chk("t1_check_unl", 32'(unlocked), 32'd0);
    tick();
    chk("t1_open_state", 32'(state_o), 32'd3);
    chk("t1_open_unl", 32'(unlocked), 32'd1);
    chk("t1_open_fail", 32'(fail_cnt), 32'd0);
    chk("t1_open_ready", 32'(key_ready), 32'd0);
    repeat (499) tick();
    chk("t1_open_last", 32'(unlocked), 32'd1);
    tick();
    chk("t1_idle_state", 32'(state_o), 32'd0);
    chk("t1_idle_unl", 32'(unlocked), 32'd0);

    // T2: wrong code then right code
    entry4(16'h1234);
    chk("t2_check_state", 32'(state_o), 32'd2);
    tick();
    chk("t2_bad_pulse", 32'(bad_code), 32'd1);
    chk("t2_fail", 32'(fail_cnt), 32'd1);
    chk("t2_idle", 32'(state_o), 32'd0);
    tick();
    chk("t2_bad_clear", 32'(bad_code), 32'd0);
    entry4(16'h1001);
    tick();
    chk("t2_open", 32'(state_o), 32'd3);
    chk("t2_fail_clr", 32'(fail_cnt), 32'd0);
    do_relock();
    chk("t2_relock", 32'(state_o), 32'd0);

    // T3: three failures -> lockout for 1000 cycles
    for (int k = 1; k <= 3; k++) begin
      entry4(16'h5555);
      tick();
      chk("t3_fail_step", 32'(fail_cnt), 32'(k));
    end
    chk("t3_lock_state", 32'(state_o), 32'd4);
    chk("t3_locked_out", 32'(locked_out), 32'd1);
    chk("t3_ready", 32'(key_ready), 32'd0);
    key_valid = 1'b1;
    key_digit = 4'd1;
    repeat (10) tick();
    key_valid = 1'b0;
    chk("t3_refused", 32'(state_o), 32'd4);
    repeat (989) tick();
    chk("t3_lock_last", 32'(locked_out), 32'd1);
    tick();
    chk("t3_release", 32'(state_o), 32'd0);
    chk("t3_fail_clr", 32'(fail_cnt), 32'd0);
    chk("t3_ready_back", 32'(key_ready), 32'd1);

    // T4: entry timeout, and a digit on the final cycle beating it
    send(4'd1);
    chk("t4_entry", 32'(state_o), 32'd1);
    repeat (1999) tick();
    chk("t4_before_to", 32'(state_o), 32'd1);
    chk("t4_no_abort", 32'(abort), 32'd0);
    tick();
    chk("t4_to_state", 32'(state_o), 32'd0);
    chk("t4_abort", 32'(abort), 32'd1);
    chk("t4_fail", 32'(fail_cnt), 32'd0);
    tick();
    chk("t4_abort_clr", 32'(abort), 32'd0);
    send(4'd1);
    repeat (1999) tick();
    send(4'd0);
    chk("t4_late_digit", 32'(state_o), 32'd1);
    chk("t4_late_noabort", 32'(abort), 32'd0);
    send(4'd0);
    send(4'd1);
    chk("t4_check", 32'(state_o), 32'd2);
    tick();
    chk("t4_open", 32'(state_o), 32'd3);

    // T5: program 7359, verify new and old codes, reset restores default
    prog_en = 1'b1;
    tick();
    chk("t5_prog_ready", 32'(key_ready), 32'd1);
    entry4(16'h7359);
    chk("t5_prog_done", 32'(prog_done), 32'd1);
    chk("t5_still_open", 32'(state_o), 32'd3);
    tick();
    chk("t5_prog_clr", 32'(prog_done), 32'd0);
    prog_en = 1'b0;
    do_relock();
    chk("t5_relock", 32'(state_o), 32'd0);
    entry4(16'h7359);
    tick();
    chk("t5_new_code", 32'(state_o), 32'd3);
    do_relock();
    entry4(16'h1001);
    tick();
    chk("t5_old_code_bad", 32'(bad_code), 32'd1);
    send(4'd1);
    send(4'd0);
    RST = 1'b1;
    tick();
    chk("t5_rst_state", 32'(state_o), 32'd0);
    chk("t5_rst_fail", 32'(fail_cnt), 32'd0);
    RST = 1'b0;
    tick();
    entry4(16'h1001);
    tick();
    chk("t5_default_back", 32'(state_o), 32'd3);

    // T6: partial programming abandoned; relock racing the final digit
    prog_en = 1'b1;
    tick();
    send(4'd2);
    send(4'd2);
    prog_en = 1'b0;
    tick();
    tick();
    do_relock();
    entry4(16'h1001);
    tick();
    chk("t6_code_kept", 32'(state_o), 32'd3);
    prog_en = 1'b1;
    tick();
    send(4'd8);
    send(4'd8);
    send(4'd8);
    key_valid = 1'b1;
    key_digit = 4'd8;
    relock    = 1'b1;
    tick();
    key_valid = 1'b0;
    relock    = 1'b0;
    prog_en   = 1'b0;
    chk("t6_relock_wins", 32'(state_o), 32'd0);
    chk("t6_no_prog_done", 32'(prog_done), 32'd0);
    entry4(16'h8888);
    tick();
    chk("t6_8888_rejected", 32'(bad_code), 32'd1);
    entry4(16'h1001);
    tick();
    chk("t6_default_ok", 32'(state_o), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
